// File: rtl/eth_fcs_tx_ctrl_pkg.sv
// Shared constants and types for the Ethernet TX FCS sequencer and CRC helper.
package eth_fcs_tx_ctrl_pkg;

  localparam int datalen = 8;
  localparam int crc_len = 32;

  // Reflected CRC-32 polynomial (LSB-first form of 32'h04C11DB7)
  localparam logic [crc_len-1:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [crc_len-1:0] CRC_PRESET    = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PAD     = 2'd2,
    FCS     = 2'd3
  } fcs_state_t;

endpackage

// File: rtl/eth_fcs_tx_ctrl_crc32_byte_update.sv
// Combinational one-byte update of a reflected CRC-32 register.
// Processes data[0] first; shared with the RX checker.
module crc32_byte_update
  import eth_fcs_tx_ctrl_pkg::*;
(
  input  logic [crc_len-1:0] crc_in,
  input  logic [datalen-1:0] data,
  output logic [crc_len-1:0] crc_out
);

  logic [crc_len-1:0] crc_v;

  // Eight unrolled shift/xor steps, one per data bit, LSB first
  always_comb begin
    crc_v = crc_in;
    for (int i = 0; i < datalen; i++) begin
      if (crc_v[0] ^ data[i]) begin
        crc_v = (crc_v >> 1) ^ CRC_POLY_REFL;
      end else begin
        crc_v = crc_v >> 1;
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/eth_fcs_tx_ctrl.sv
// TX sequencer: forwards payload bytes, zero-pads short frames to MIN_LEN,
// then appends the 4-byte Ethernet FCS through one registered output stage.
module eth_fcs_tx_ctrl
  import eth_fcs_tx_ctrl_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int CNT_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [datalen-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [7:0]         m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic               tx_done
);

  localparam logic [CNT_W:0] MIN_LEN_W = (CNT_W+1)'(MIN_LEN);

  fcs_state_t         state_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [1:0]         fcs_idx_q;
  logic [crc_len-1:0] crc_q;
  logic [7:0]         m_data_q;
  logic               m_valid_q;
  logic               m_last_q;
  logic               tx_done_q;

  logic               adv;
  logic               in_payload;
  logic [datalen-1:0] crc_din;
  logic [crc_len-1:0] crc_d;
  logic [crc_len-1:0] fcs_val;
  logic [7:0]         fcs_byte;
  logic               cnt_sat;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W:0]     cnt_plus1;
  logic               pad_needed;
  logic               pad_finish;

  // The output register may load when empty or when its byte is taken
  assign adv        = !m_valid_q || m_ready;
  assign in_payload = (state_q == IDLE) || (state_q == PAYLOAD);
  assign s_ready    = adv && in_payload;

  // Padding feeds zero bytes into the CRC; otherwise the accepted payload byte
  assign crc_din = (state_q == PAD) ? '0 : s_data;

  crc32_byte_update u_crc (
    .crc_in  (crc_q),
    .data    (crc_din),
    .crc_out (crc_d)
  );

  // Counter saturates so very long frames never wrap back into padding
  assign cnt_sat    = &byte_cnt_q;
  assign cnt_inc    = cnt_sat ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
  assign cnt_plus1  = {1'b0, byte_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign pad_needed = !cnt_sat && (cnt_plus1 < MIN_LEN_W);
  assign pad_finish = cnt_sat || (cnt_plus1 >= MIN_LEN_W);

  assign fcs_val = ~crc_q;

  // Select FCS byte, least significant byte goes out first
  always_comb begin
    fcs_byte = fcs_val[7:0];
    case (fcs_idx_q)
      2'd1:    fcs_byte = fcs_val[15:8];
      2'd2:    fcs_byte = fcs_val[23:16];
      2'd3:    fcs_byte = fcs_val[31:24];
      default: fcs_byte = fcs_val[7:0];
    endcase
  end

  // Frame sequencer and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      fcs_idx_q  <= '0;
      crc_q      <= CRC_PRESET;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= m_valid_q && m_ready && m_last_q;
      if (adv) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
        case (state_q)
          IDLE, PAYLOAD: begin
            if (s_valid) begin
              m_data_q   <= s_data;
              m_valid_q  <= 1'b1;
              crc_q      <= crc_d;
              byte_cnt_q <= cnt_inc;
              if (s_last) begin
                if (pad_needed) begin
                  state_q <= PAD;
                end else begin
                  state_q   <= FCS;
                  fcs_idx_q <= '0;
                end
              end else begin
                state_q <= PAYLOAD;
              end
            end
          end
          PAD: begin
            m_data_q   <= 8'h00;
            m_valid_q  <= 1'b1;
            crc_q      <= crc_d;
            byte_cnt_q <= cnt_inc;
            if (pad_finish) begin
              state_q   <= FCS;
              fcs_idx_q <= '0;
            end
          end
          FCS: begin
            m_data_q  <= fcs_byte;
            m_valid_q <= 1'b1;
            fcs_idx_q <= fcs_idx_q + 2'd1;
            if (fcs_idx_q == 2'd3) begin
              m_last_q   <= 1'b1;
              crc_q      <= CRC_PRESET;
              byte_cnt_q <= '0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_eth_fcs_tx_ctrl.sv
// Scoreboard bench: two instances (no padding / 60-byte minimum) driven with
// directed and random frames, checked against a software CRC-32 frame model.
module tb_eth_fcs_tx_ctrl;
  import eth_fcs_tx_ctrl_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data  [2];
  logic       s_valid [2];
  logic       s_last  [2];
  logic       s_ready [2];
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  logic       m_last  [2];
  logic       m_ready [2];
  logic       busy    [2];
  logic       tx_done [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  int         len_q0[$];
  int         len_q1[$];
  int         frames_pushed [2];
  int         frames_done   [2];
  int         rmode [2];
  int         ph    [2];

  always #5 clk = ~clk;

  eth_fcs_tx_ctrl #(.MIN_LEN(0), .CNT_W(12)) u_dut0 (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
    .m_ready(m_ready[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  eth_fcs_tx_ctrl #(.MIN_LEN(60), .CNT_W(12)) u_dut60 (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
    .m_ready(m_ready[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s dut%0d: got %h expected %h", name, idx, act, exp);
  endtask

  // Standard table-free software CRC-32 over a whole buffer, returns the FCS value
  function automatic logic [31:0] sw_fcs(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      c = c ^ {24'h0, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    return q;
  endfunction

  function automatic void push_exp(input int idx, input logic [8:0] v);
    if (idx == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction

  function automatic int qsize(input int idx);
    return (idx == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [8:0] pop_exp(input int idx);
    if (idx == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Expected wire image: payload, zero pad to minimum, FCS little-endian
  task automatic model_frame(input int idx, input bq_t pl);
    bq_t fr;
    logic [31:0] f;
    int min_len;
    min_len = (idx == 0) ? 0 : 60;
    fr = pl;
    while (fr.size() < min_len) fr.push_back(8'h00);
    f = sw_fcs(fr);
    foreach (fr[k]) push_exp(idx, {1'b0, fr[k]});
    for (int k = 0; k < 4; k++) push_exp(idx, {(k == 3), f[8*k +: 8]});
    if (idx == 0) len_q0.push_back(fr.size() + 4); else len_q1.push_back(fr.size() + 4);
    frames_pushed[idx]++;
  endtask

  // Present bytes upstream; entered and left #1 after a rising edge
  task automatic send_raw(input int idx, input bq_t pl, input bit mark_last, input bit gaps);
    logic acc;
    for (int k = 0; k < pl.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid[idx] = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid[idx] = 1'b1;
      s_data[idx]  = pl[k];
      s_last[idx]  = mark_last && (k == pl.size() - 1);
      acc = 1'b0;
      for (int w = 0; w < 200 && !acc; w++) begin
        @(negedge clk);
        acc = s_ready[idx];
        @(posedge clk); #1;
      end
      check("accept", idx, acc, 1);
    end
    s_valid[idx] = 1'b0;
    s_last[idx]  = 1'b0;
  endtask

  task automatic send_frame(input int idx, input bq_t pl, input bit gaps);
    model_frame(idx, pl);
    send_raw(idx, pl, 1'b1, gaps);
  endtask

  task automatic drain(input int idx);
    for (int w = 0; w < 3000 && qsize(idx) != 0; w++) @(posedge clk);
    check("drain", idx, qsize(idx), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Downstream ready generator: always / 1,0,0,1,0 pattern / random
  initial begin
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        case (rmode[i])
          0: m_ready[i] = 1'b1;
          1: begin
            m_ready[i] = (ph[i] % 5 == 0) || (ph[i] % 5 == 3);
            ph[i]++;
          end
          default: m_ready[i] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Monitor: compares every accepted output byte and the handshake rules
  logic       prev_stall [2];
  logic [7:0] prev_data  [2];
  logic       prev_last  [2];
  logic       prev_fin   [2];
  logic       prev_fin_sv[2];
  logic       post_last  [2];
  int         out_cnt    [2];

  initial begin
    logic [8:0] e;
    logic hs;
    for (int i = 0; i < 2; i++) begin
      prev_stall[i] = 0; prev_fin[i] = 0; prev_fin_sv[i] = 0; post_last[i] = 0; out_cnt[i] = 0;
      prev_data[i] = 0; prev_last[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          prev_stall[i] = 0; prev_fin[i] = 0; prev_fin_sv[i] = 0; post_last[i] = 0; out_cnt[i] = 0;
        end else begin
          if (tx_done[i] || prev_fin[i]) check("tx_done", i, tx_done[i], prev_fin[i]);
          if (prev_fin_sv[i]) check("b2b_no_bubble", i, m_valid[i], 1);
          if (prev_stall[i]) begin
            check("hold_valid", i, m_valid[i], 1);
            check("hold_data", i, m_data[i], prev_data[i]);
            check("hold_last", i, m_last[i], prev_last[i]);
          end
          if (post_last[i] && !(m_valid[i] && m_last[i]))
            check("s_ready_pad_fcs", i, s_ready[i], 0);
          hs = m_valid[i] && m_ready[i];
          if (hs) begin
            check("exp_avail", i, (qsize(i) > 0), 1);
            if (qsize(i) > 0) begin
              e = pop_exp(i);
              out_cnt[i]++;
              check("m_data", i, m_data[i], e[7:0]);
              check("m_last", i, m_last[i], e[8]);
              if (m_last[i]) begin
                check("frame_len", i, out_cnt[i], (i == 0) ? len_q0.pop_front() : len_q1.pop_front());
                out_cnt[i] = 0;
                frames_done[i]++;
              end
            end
          end
          if (hs && m_last[i]) post_last[i] = 0;
          if (s_valid[i] && s_ready[i] && s_last[i]) post_last[i] = 1;
          prev_fin[i]    = hs && m_last[i];
          prev_fin_sv[i] = hs && m_last[i] && s_valid[i];
          prev_stall[i]  = m_valid[i] && !m_ready[i];
          prev_data[i]   = m_data[i];
          prev_last[i]   = m_last[i];
        end
      end
    end
  end

  initial begin
    bq_t p;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = 0; s_valid[i] = 0; s_last[i] = 0;
      rmode[i] = 0; ph[i] = 0; frames_pushed[i] = 0; frames_done[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_m_valid", i, m_valid[i], 0);
      check("rst_m_last", i, m_last[i], 0);
      check("rst_m_data", i, m_data[i], 0);
      check("rst_tx_done", i, tx_done[i], 0);
      check("rst_busy", i, busy[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // "123456789" without padding, then the pangram
    send_frame(0, str2q("123456789"), 0);
    drain(0);
    send_frame(0, str2q("The quick brown fox jumps over the lazy dog"), 0);
    drain(0);

    // Single byte padded to 60
    p = {};
    p.push_back(8'hAA);
    send_frame(1, p, 0);
    drain(1);

    // Backpressure pattern on dut0 alongside random frames on dut60
    rmode[0] = 1; ph[0] = 0; rmode[1] = 2;
    fork
      begin
        send_frame(0, str2q("123456789"), 1);
        drain(0);
      end
      begin
        int lens[6];
        lens = '{59, 60, 61, 2, 75, 0};
        for (int f = 0; f < 6; f++) begin
          int n;
          bq_t rp;
          n = (lens[f] == 0) ? $urandom_range(1, 90) : lens[f];
          rp = {};
          for (int k = 0; k < n; k++) rp.push_back(8'($urandom_range(0, 255)));
          send_frame(1, rp, 1);
        end
        drain(1);
      end
    join
    rmode[0] = 0; rmode[1] = 0;
    repeat (2) @(posedge clk); #1;

    // Back-to-back frames with s_valid never dropping
    send_frame(0, str2q("123456789"), 0);
    send_frame(0, str2q("123456789"), 0);
    drain(0);

    // Reset after five payload bytes; the partial frame must vanish
    p = str2q("12345");
    foreach (p[k]) push_exp(0, {1'b0, p[k]});
    send_raw(0, p, 1'b0, 1'b0);
    s_valid[0] = 1'b1; s_data[0] = 8'h36;
    rst = 1'b1;
    exp_q0 = {};
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_m_valid", 0, m_valid[0], 0);
    check("rst_mid_busy", 0, busy[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(0, str2q("123456789"), 0);
    drain(0);

    for (int i = 0; i < 2; i++) check("frames", i, frames_done[i], frames_pushed[i]);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
